// File: rtl/addsub_rf_ctrl_pkg.sv
// Shared constants for the add/sub register-file controller: widths, opcodes, FSM encoding.
package addsub_rf_ctrl_pkg;

    localparam int unsigned BwGf    = 192;
    localparam int unsigned NReg    = 8;
    localparam int unsigned RegIdxW = 3;

    localparam logic [1:0] OpLoad = 2'd0;
    localparam logic [1:0] OpAdd  = 2'd1;
    localparam logic [1:0] OpSub  = 2'd2;
    localparam logic [1:0] OpRead = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

endpackage

// File: rtl/gf_regfile.sv
// Field-element register file: one synchronous write port, two asynchronous read ports,
// synchronous reset to zero.
module gf_regfile
    import addsub_rf_ctrl_pkg::*;
#(
    parameter int unsigned Width = BwGf,
    parameter int unsigned Depth = NReg
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [RegIdxW-1:0] waddr_i,
    input  logic [Width-1:0]   wdata_i,
    input  logic [RegIdxW-1:0] raddr_a_i,
    input  logic [RegIdxW-1:0] raddr_b_i,
    output logic [Width-1:0]   rdata_a_o,
    output logic [Width-1:0]   rdata_b_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/addsub_rf_ctrl.sv
// Sequences LOAD/READ/ADD/SUB commands between a register file and an external
// modular adder, with one operation in flight and a sticky adder-timeout flag.
module addsub_rf_ctrl
    import addsub_rf_ctrl_pkg::*;
#(
    parameter int unsigned BW_GF   = BwGf,
    parameter int unsigned NREG    = NReg,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [RegIdxW-1:0] cmd_dst,
    input  logic [RegIdxW-1:0] cmd_src_a,
    input  logic [RegIdxW-1:0] cmd_src_b,
    input  logic [BW_GF-1:0]   cmd_data,
    output logic               add_en,
    output logic [BW_GF-1:0]   add_a,
    output logic [BW_GF-1:0]   add_b,
    output logic               add_is_sub,
    input  logic [BW_GF-1:0]   add_out,
    input  logic               add_valid,
    output logic [BW_GF-1:0]   rd_data,
    output logic               rd_valid,
    output logic               done,
    output logic               err
);

    localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e               state_q;
    logic [RegIdxW-1:0]   dst_q;
    logic [WdW-1:0]       wdog_q;
    logic [WdW-1:0]       wdog_d;
    logic                 cmd_accept;
    logic                 rf_we;
    logic [RegIdxW-1:0]   rf_waddr;
    logic [BW_GF-1:0]     rf_wdata;
    logic [BW_GF-1:0]     rf_rdata_a;
    logic [BW_GF-1:0]     rf_rdata_b;

    assign cmd_ready  = (state_q == StIdle) && !rst;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign wdog_d     = wdog_q + WdW'(1);

    // LOAD and adder write-back can never coincide: LOAD is only accepted in IDLE.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = cmd_dst;
        rf_wdata = cmd_data;
        if (cmd_accept && (cmd_op == OpLoad)) begin
            rf_we = 1'b1;
        end else if ((state_q == StWait) && add_valid) begin
            rf_we    = 1'b1;
            rf_waddr = dst_q;
            rf_wdata = add_out;
        end
    end

    gf_regfile #(
        .Width (BW_GF),
        .Depth (NREG)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (cmd_src_a),
        .raddr_b_i (cmd_src_b),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dst_q      <= '0;
            wdog_q     <= '0;
            add_en     <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_is_sub <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            add_en   <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_accept) begin
                        unique case (cmd_op)
                            OpLoad: ;
                            OpRead: begin
                                rd_data  <= rf_rdata_a;
                                rd_valid <= 1'b1;
                            end
                            OpAdd, OpSub: begin
                                add_a      <= rf_rdata_a;
                                add_b      <= rf_rdata_b;
                                add_is_sub <= (cmd_op == OpSub);
                                dst_q      <= cmd_dst;
                                add_en     <= 1'b1;
                                state_q    <= StIssue;
                            end
                        endcase
                    end
                end
                StIssue: begin
                    wdog_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (add_valid) begin
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end else if (wdog_d == WdW'(TIMEOUT)) begin
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/addsub_rf_ctrl.md
ADDSUB_RF_CTRL -- requirements
Module: addsub_rf_ctrl

Interface
REQ-001 SHALL have parameters: BW_GF, default 192, field-element width; NREG, default 8, register count; TIMEOUT, default 63, maximum wait cycles for an adder result.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command: 0 LOAD, 1 ADD, 2 SUB, 3 READ.
- cmd_dst  in  3  destination register (LOAD/ADD/SUB).
- cmd_src_a  in  3  first source register (ADD/SUB/READ).
- cmd_src_b  in  3  second source register (ADD/SUB).
- cmd_data  in  BW_GF  LOAD value, already reduced mod p.
- add_en  out  1  one-cycle start pulse to ADD_192.
- add_a  out  BW_GF  adder operand a.
- add_b  out  BW_GF  adder operand b.
- add_is_sub  out  1  1 = a-b mod p, 0 = a+b mod p.
- add_out  in  BW_GF  adder result.
- add_valid  in  1  adder result-valid pulse.
- rd_data  out  BW_GF  READ result.
- rd_valid  out  1  rd_data valid pulse.
- done  out  1  ADD/SUB written back pulse.
- err  out  1  sticky adder-timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT; cmd_ready = 1 only in IDLE.
REQ-004 LOAD accepted at edge N SHALL write cmd_data to cmd_dst at edge N; the FSM SHALL remain in IDLE, so back-to-back LOADs run at one per cycle.
REQ-005 READ accepted at edge N SHALL drive rd_data = reg[cmd_src_a] with rd_valid = 1 for exactly the cycle after edge N; the FSM SHALL remain in IDLE.
REQ-006 ADD/SUB accepted at edge N SHALL latch reg[src_a], reg[src_b], dst and op into add_a, add_b, dst_q and add_is_sub at edge N, then go to ISSUE.
REQ-007 In ISSUE, add_en SHALL be 1 for exactly one cycle; the FSM SHALL then go to WAIT.
REQ-008 add_a, add_b and add_is_sub SHALL hold stable from ISSUE until the FSM leaves WAIT.
REQ-009 In WAIT, add_valid = 1 SHALL write add_out to reg[dst_q], pulse done for one cycle and return the FSM to IDLE, all on the same edge.
REQ-010 The watchdog counter SHALL clear on entering WAIT and increment each WAIT cycle without add_valid; at TIMEOUT it SHALL set err, perform no write, and return to IDLE.
REQ-011 add_valid SHALL be ignored outside WAIT, with no write and no done.
REQ-012 dst equal to src_a or src_b SHALL be legal; operands are latched first, so the result overwrites the source.
REQ-013 src_a == src_b SHALL be legal, e.g. SUB r,r gives 0 and ADD r,r gives 2r mod p.
REQ-014 The block SHALL perform no arithmetic; all modular arithmetic stays in the adder.
REQ-015 The block SHALL keep at most one ADD/SUB outstanding.
REQ-016 err SHALL be sticky until reset and SHALL not block later commands.
REQ-017 The latency of ADD/SUB from accept to done SHALL be 2 cycles plus the adder latency.

Reset
REQ-018 rst SHALL, on the next clk edge, force: FSM to IDLE, all registers to 0, watchdog to 0, add_en/rd_valid/done/err to 0, and add_a/add_b/add_is_sub/rd_data to 0.
REQ-019 rst asserted during ISSUE or WAIT SHALL abandon the operation with no write-back; an add_valid arriving after reset SHALL be ignored (REQ-011).
REQ-020 cmd_ready SHALL be 0 while rst = 1.

Structure
REQ-021 A shared package SHALL hold BW_GF, NREG, the register-index width (3), the opcode constants (LOAD/ADD/SUB/READ) and the FSM state encoding.
REQ-022 The register file SHALL be a sub-module gf_regfile: NREG x BW_GF, one synchronous write port, two asynchronous read ports, synchronous reset to 0.
REQ-023 ADD_192 SHALL be external to this block, connected by the bench or the parent.

Verification
REQ-024 The bench SHALL connect the real ADD_192 and SHALL cover:
- LOAD r0=5, r1=7; ADD r2=r0+r1; READ r2 -> rd_data = 12, done pulses once, add_en high exactly 1 cycle.
- SUB r3=r0-r1; READ r3 -> rd_data = p-2 = 0xFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFD.
- LOAD r4=p-1; ADD r4=r4+r4 -> r4 = p-2; SUB r5=r4-r4 -> r5 = 0.
- Replace adder with a stub that never asserts add_valid; issue ADD -> err = 1 after TIMEOUT WAIT cycles, dst unchanged, cmd_ready = 1 again.
- Pulse rst during WAIT, then apply a late add_valid -> no write, all registers 0, done = 0.
- Back-to-back LOADs at one per cycle to r0..r7; READ each -> correct values; cmd_ready low during an ADD/SUB, high otherwise.
